mem_bank_config_sequencer: RTL and testbench

Configuration-write sequencer for memory-bank (BL/WL) programmed fabric. Accepts a serial configuration bitstream over a valid/ready handshake. Walks every cell in row-major order (BL inner, WL outer) and drives the bitline and wordline decoders' enable, address and data inputs with setup/pulse/hold timing. Sits directly upstream of the 5-to-19 BL and WL decoders; its outputs connect straight to them.

---
 rtl/mem_bank_config_sequencer.sv | 154 +++++++++++++++
 tb/tb_mem_bank_config_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_config_sequencer.sv
// Configuration-write sequencer for a memory-bank (BL/WL) programmed fabric.
// It takes one configuration bit per cell over a valid/ready handshake.
// It visits every cell in row-major order: the bitline is the inner loop and
// the wordline is the outer loop.
// For each cell it gives the BL/WL decoders a setup / pulse / hold sequence.
// The outputs feed the decoder enable, addr_in and data_in pins directly.

module mem_bank_config_sequencer #(
    parameter int BL_NUM       = 19,
    parameter int WL_NUM       = 19,
    parameter int ADDR_W       = 5,
    parameter int PULSE_CYCLES = 2
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic              bit_ready,
    output logic              bl_enable,
    output logic [ADDR_W-1:0] bl_addr,
    output logic              bl_data,
    output logic              wl_enable,
    output logic [ADDR_W-1:0] wl_addr,
    output logic              busy,
    output logic              done
);

    // State encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    // The pulse counter only has to reach PULSE_CYCLES-1.
    localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] BL_LAST    = ADDR_W'(BL_NUM - 1);
    localparam logic [ADDR_W-1:0] WL_LAST    = ADDR_W'(WL_NUM - 1);
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] pulse_cnt;
    logic             bl_last;
    logic             wl_last;
    logic             accept;
    logic             start_ok;
    logic             advance;

    // Address-wrap detection for the current cell.
    assign bl_last = (bl_addr == BL_LAST);
    assign wl_last = (wl_addr == WL_LAST);

    // A write starts only from IDLE. If abort is high in the same cycle, the
    // write does not start.
    assign start_ok = (state == ST_IDLE) && start && !abort;

    // A bit is consumed only in LOAD. If abort is high in the same cycle, the
    // bit is left unconsumed.
    assign accept = (state == ST_LOAD) && bit_valid && !abort;

    // The cell is finished and the next LOAD follows, so the address steps.
    assign advance = (state == ST_HOLD) && !abort && !(bl_last && wl_last);

    // Next-state decode. Abort sends any active state back to IDLE.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE:  if (start_ok) state_next = ST_LOAD;
            ST_LOAD:  if (bit_valid) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_PULSE;
            ST_PULSE: if (pulse_cnt == PULSE_LAST) state_next = ST_HOLD;
            ST_HOLD:  state_next = (bl_last && wl_last) ? ST_IDLE : ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge prog_clk) begin
        // NOTE: sequential state uses non-blocking assignments, so all flops update together.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts the cycles spent in PULSE. It is cleared whenever PULSE is not continuing.
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            pulse_cnt <= '0;
        end else if ((state == ST_PULSE) && (state_next == ST_PULSE)) begin
            pulse_cnt <= pulse_cnt + CNT_W'(1);
        end else begin
            pulse_cnt <= '0;
        end
    end

    // Cell address. It changes only when a write starts or a cell finishes.
    // After an abort it keeps its last value.
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            bl_addr <= '0;
            wl_addr <= '0;
        end else if (start_ok) begin
            bl_addr <= '0;
            wl_addr <= '0;
        end else if (advance) begin
            if (bl_last) begin
                bl_addr <= '0;
                wl_addr <= wl_addr + ADDR_W'(1);
            end else begin
                bl_addr <= bl_addr + ADDR_W'(1);
            end
        end
    end

    // Data bit for the current cell. It is captured at the handshake and held
    // through SETUP, PULSE and HOLD.
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            bl_data <= 1'b0;
        end else if (accept) begin
            bl_data <= bit_data;
        end
    end

    // Sticky completion flag. An accepted start clears it. It is set only
    // when the last cell finishes without an abort.
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            done <= 1'b0;
        end else if (start_ok) begin
            done <= 1'b0;
        end else if ((state == ST_HOLD) && !abort && bl_last && wl_last) begin
            done <= 1'b1;
        end
    end

    // These outputs decode the state register only. bit_ready therefore has
    // no combinational path from bit_valid.
    assign bit_ready = (state == ST_LOAD);
    assign bl_enable = (state == ST_PULSE);
    assign wl_enable = (state == ST_PULSE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_bank_config_sequencer.sv
// Self-checking bench for mem_bank_config_sequencer.
// Two instances share one stimulus stream: a small 3x2 array and the
// default 19x19 array.
// A cell-index reference model predicts every output of both instances on every cycle.

module tb_mem_bank_config_sequencer;

    localparam int AW   = 5;
    localparam int A_BL = 3;
    localparam int A_WL = 2;
    localparam int A_PC = 2;
    localparam int B_BL = 19;
    localparam int B_WL = 19;
    localparam int B_PC = 2;

    logic prog_clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_data = 1'b0;

    logic a_bit_ready, a_bl_enable, a_bl_data, a_wl_enable, a_busy, a_done;
    logic [AW-1:0] a_bl_addr, a_wl_addr;
    logic b_bit_ready, b_bl_enable, b_bl_data, b_wl_enable, b_busy, b_done;
    logic [AW-1:0] b_bl_addr, b_wl_addr;

    int n_checks = 0;
    int n_fail = 0;

    always #5 prog_clk = ~prog_clk;

    mem_bank_config_sequencer #(
        .BL_NUM(A_BL), .WL_NUM(A_WL), .ADDR_W(AW), .PULSE_CYCLES(A_PC)
    ) dut_a (
        .prog_clk(prog_clk), .reset(reset), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(a_bit_ready),
        .bl_enable(a_bl_enable), .bl_addr(a_bl_addr), .bl_data(a_bl_data),
        .wl_enable(a_wl_enable), .wl_addr(a_wl_addr), .busy(a_busy), .done(a_done)
    );

    mem_bank_config_sequencer #(
        .BL_NUM(B_BL), .WL_NUM(B_WL), .ADDR_W(AW), .PULSE_CYCLES(B_PC)
    ) dut_b (
        .prog_clk(prog_clk), .reset(reset), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(b_bit_ready),
        .bl_enable(b_bl_enable), .bl_addr(b_bl_addr), .bl_data(b_bl_data),
        .wl_enable(b_wl_enable), .wl_addr(b_wl_addr), .busy(b_busy), .done(b_done)
    );

    // Reference model. A write is described by a linear cell index and by the
    // number of cycles t since that cell's bit was taken. Cycle 1 is setup,
    // cycles 2..pc+1 are the pulse, and cycle pc+2 is hold.
    typedef struct packed {
        logic busy;
        logic waiting;
        int   t;
        int   idx;
        logic data;
        logic done;
    } model_t;

    model_t ma = '0;
    model_t mb = '0;

    function automatic model_t step(model_t m, int nbl, int nwl, int pc,
                                    logic rst, logic st, logic ab, logic v, logic d);
        model_t n;
        n = m;
        if (rst) begin
            n = '0;
        end else if (!m.busy) begin
            if (st && !ab) begin
                n.busy = 1'b1;
                n.waiting = 1'b1;
                n.idx = 0;
                n.t = 0;
                n.done = 1'b0;
            end
        end else if (ab) begin
            n.busy = 1'b0;
            n.waiting = 1'b0;
            n.t = 0;
        end else if (m.waiting) begin
            if (v) begin
                n.data = d;
                n.waiting = 1'b0;
                n.t = 1;
            end
        end else if (m.t == pc + 2) begin
            n.t = 0;
            if (m.idx == nbl * nwl - 1) begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end else begin
                n.idx = m.idx + 1;
                n.waiting = 1'b1;
            end
        end else begin
            n.t = m.t + 1;
        end
        return n;
    endfunction

    // Expected output vector, packed as {rdy, ble, wle, busy, done, data, bl_addr, wl_addr}.
    function automatic logic [31:0] expect_outs(model_t m, int nbl, int pc);
        logic en;
        logic [AW-1:0] bl;
        logic [AW-1:0] wl;
        en = m.busy && !m.waiting && (m.t >= 2) && (m.t <= pc + 1);
        bl = AW'(m.idx % nbl);
        wl = AW'(m.idx / nbl);
        return {16'd0, m.busy && m.waiting, en, en, m.busy, m.done, m.data, bl, wl};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance. The inputs are sampled at the same edge as the DUT.
    always @(posedge prog_clk) begin
        ma <= step(ma, A_BL, A_WL, A_PC, reset, start, abort, bit_valid, bit_data);
        mb <= step(mb, B_BL, B_WL, B_PC, reset, start, abort, bit_valid, bit_data);
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge prog_clk);
            #1;
            check("a_outs", {16'd0, a_bit_ready, a_bl_enable, a_wl_enable, a_busy, a_done,
                             a_bl_data, a_bl_addr, a_wl_addr}, expect_outs(ma, A_BL, A_PC));
            check("b_outs", {16'd0, b_bit_ready, b_bl_enable, b_wl_enable, b_busy, b_done,
                             b_bl_data, b_bl_addr, b_wl_addr}, expect_outs(mb, B_BL, B_PC));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge prog_clk);
        #2;
    endtask

    int exp_wl[6] = '{0, 0, 0, 1, 1, 1};
    int exp_bl[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        logic acc_bits[$];
        int   p_wl[$];
        int   p_bl[$];
        logic p_data[$];
        int   widths[$];
        int   width;
        logic prev_en;
        int   done_at;
        logic prev_data;
        int   b_pulses, b_acc, b_stab_err, b_max_bl, b_max_wl;
        logic [AW-1:0] cap_bl, cap_wl;
        logic cap_d, b_prev_en, finished;

        // Reset state.
        cyc(3);
        check("reset_a_ble", a_bl_enable, 0);
        check("reset_a_busy", a_busy, 0);
        check("reset_a_done", a_done, 0);
        check("reset_a_rdy", a_bit_ready, 0);
        reset = 1'b0;
        cyc(1);

        // Full 3x2 write with bit_valid held high.
        bit_valid = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        prev_en = 1'b0;
        width = 0;
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            bit_data = 1'($urandom);
            if (a_bit_ready) acc_bits.push_back(bit_data);
            cyc(1);
            if (a_bl_enable && !prev_en) begin
                p_wl.push_back(int'(a_wl_addr));
                p_bl.push_back(int'(a_bl_addr));
                p_data.push_back(a_bl_data);
                width = 0;
            end
            if (a_bl_enable) width++;
            if (!a_bl_enable && prev_en) widths.push_back(width);
            prev_en = a_bl_enable;
            if (a_done && done_at < 0) done_at = c;
        end
        check("full_pulse_count", p_wl.size(), 6);
        check("full_accept_count", acc_bits.size(), 6);
        check("full_width_count", widths.size(), 6);
        for (int i = 0; i < 6 && i < p_wl.size() && i < acc_bits.size() && i < widths.size(); i++) begin
            check("full_wl_seq", p_wl[i], exp_wl[i]);
            check("full_bl_seq", p_bl[i], exp_bl[i]);
            check("full_data_seq", p_data[i], acc_bits[i]);
            check("full_width", widths[i], 2);
        end
        check("full_done_latency", done_at, 30);

        // Reset while the enables are high on cell (0,2).
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int i = 0; i < 100 && !(a_bl_enable && a_bl_addr == 2); i++) cyc(1);
        check("rst_wait_pulse", a_bl_enable && a_bl_addr == 2, 1);
        reset = 1'b1;
        cyc(1);
        check("rst_ble", a_bl_enable, 0);
        check("rst_wle", a_wl_enable, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_addr", {a_wl_addr, a_bl_addr}, 0);
        reset = 1'b0;
        cyc(1);
        check("rst_idle", {a_busy, a_bit_ready}, 0);

        // Backpressure on cell (0,1).
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int i = 0; i < 100 && !a_bl_enable; i++) cyc(1);
        bit_valid = 1'b0;
        for (int i = 0; i < 100 && !a_bit_ready; i++) cyc(1);
        check("bp_in_load", a_bit_ready, 1);
        check("bp_cell", a_bl_addr, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            check("bp_stall", {a_bit_ready, a_bl_enable, a_busy}, 3'b101);
        end
        bit_valid = 1'b1;
        cyc(1);
        check("bp_setup", {a_bit_ready, a_bl_enable}, 2'b00);
        cyc(1);
        check("bp_resume", {a_bl_enable, a_bl_addr}, {1'b1, 5'd1});

        // Abort in LOAD at cell (1,0) while a bit is offered.
        for (int i = 0; i < 100 && !(a_bit_ready && a_wl_addr == 1 && a_bl_addr == 0); i++) cyc(1);
        check("abort_wait", a_bit_ready && a_wl_addr == 1 && a_bl_addr == 0, 1);
        prev_data = a_bl_data;
        bit_data = ~prev_data;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_idle", {a_busy, a_bit_ready, a_done}, 0);
        check("abort_addr_kept", {a_wl_addr, a_bl_addr}, {5'd1, 5'd0});
        check("abort_bit_not_taken", a_bl_data, prev_data);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart", {a_bit_ready, a_busy, a_wl_addr, a_bl_addr}, {2'b11, 10'd0});

        // start while busy is ignored, so the write keeps advancing.
        for (int i = 0; i < 100 && !(a_bl_enable && a_bl_addr == 2 && a_wl_addr == 0); i++) cyc(1);
        start = 1'b1;
        cyc(6);
        start = 1'b0;
        check("busy_start_ignored", {a_busy, a_wl_addr, a_bl_addr}, {1'b1, 5'd1, 5'd0});

        // start together with abort in IDLE is ignored.
        for (int i = 0; i < 100 && !a_done; i++) cyc(1);
        check("second_done", a_done, 1);
        start = 1'b1;
        abort = 1'b1;
        cyc(2);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {a_busy, a_done, a_wl_addr, a_bl_addr}, {2'b01, 5'd1, 5'd2});

        // Full 19x19 write with random valid gaps and random bits.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        b_pulses = 0;
        b_acc = 0;
        b_stab_err = 0;
        b_max_bl = 0;
        b_max_wl = 0;
        b_prev_en = 1'b0;
        cap_bl = '0;
        cap_wl = '0;
        cap_d = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 4000 && !finished; i++) begin
            bit_valid = ($urandom_range(0, 3) != 0);
            bit_data = 1'($urandom);
            if (b_bit_ready && bit_valid) b_acc++;
            cyc(1);
            if (b_bl_enable != b_wl_enable) b_stab_err++;
            if (b_bl_enable) begin
                if (!b_prev_en) begin
                    b_pulses++;
                    cap_bl = b_bl_addr;
                    cap_wl = b_wl_addr;
                    cap_d = b_bl_data;
                end else if ({cap_bl, cap_wl, cap_d} != {b_bl_addr, b_wl_addr, b_bl_data}) begin
                    b_stab_err++;
                end
            end
            b_prev_en = b_bl_enable;
            if (int'(b_bl_addr) > b_max_bl) b_max_bl = int'(b_bl_addr);
            if (int'(b_wl_addr) > b_max_wl) b_max_wl = int'(b_wl_addr);
            finished = b_done;
        end
        check("big_done", b_done, 1);
        check("big_pulses", b_pulses, 361);
        check("big_accepts", b_acc, 361);
        check("big_max_bl", b_max_bl, 18);
        check("big_max_wl", b_max_wl, 18);
        check("big_stability", b_stab_err, 0);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
